instr_loader: RTL

- Boot-time instruction loader: the writer side of the core's `instr_in`/`instr_in_addr` instruction-load port.
- Receives a framed byte stream (count, payload, checksum) over a valid/ready byte interface.
- Assembles little-endian 32-bit words and issues one write strobe per word at consecutive word addresses.
- Holds the core in reset until a complete, checksum-valid image has been written.

---
 rtl/instr_loader_pkg.sv | 25 ++
 rtl/instr_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg
//   Shared types and constants for the boot-time instruction loader.
//   - state_t      : loader FSM states
//   - COUNT_BYTES  : number of little-endian word-count bytes leading a frame
//   - word_addr()  : byte address of instruction word <idx> relative to a base
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam int COUNT_BYTES = 2;

  // Wraps modulo 2^32 by construction of the 32-bit add.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [29:0] idx);
    return base + {idx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_loader.sv
// instr_loader
//   Boot-time instruction loader. Accepts a framed byte stream
//   (count_lo, count_hi, 4*N payload bytes, XOR checksum), assembles
//   little-endian 32-bit words and writes them at consecutive word addresses
//   starting at BASE_ADDR. The core is held in reset until a complete,
//   checksum-valid image has been written.
//
// Handshake: a byte transfers on a rising edge where byte_valid & byte_ready.
//   byte_ready is a registered output; it is high in IDLE/CNT_HI/DATA/CHECK
//   and low in DONE/ERROR and during reset. The producer may hold byte_valid
//   low for any number of cycles; lane and word index survive such gaps.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   pulse; DONE/ERROR -> IDLE for a new load
//   byte_in       in   [7:0] stream byte
//   byte_valid    in   byte_in valid
//   byte_ready    out  loader accepts a byte this cycle
//   instr_in      out  [31:0] assembled instruction word
//   instr_in_addr out  [31:0] byte address for instr_in
//   instr_we      out  one-cycle write strobe
//   core_reset_n  out  active-low core reset, high only in DONE
//   done          out  load complete, checksum good
//   err           out  bad checksum or oversize count
//   dbg_state_o   out  current FSM state (debug/observability)
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] instr_in,
  output logic [31:0] instr_in_addr,
  output logic        instr_we,
  output logic        core_reset_n,
  output logic        done,
  output logic        err,
  output state_t      dbg_state_o
);

  localparam int          IW    = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t                   state_q, state_d;
  logic [8*COUNT_BYTES-1:0] count_q;
  logic [IW-1:0]            idx_q;
  logic [1:0]               lane_q;
  logic [23:0]              word_q;      // lanes 0..2; lane 3 goes straight out
  logic [7:0]               chk_q;
  logic                     byte_ready_q;
  logic [31:0]              instr_q;
  logic [31:0]              addr_q;
  logic                     we_q;
  logic                     core_rst_n_q;
  logic                     done_q;
  logic                     err_q;

  logic        xfer;
  logic [31:0] count_full;
  logic        last_word;

  assign xfer       = byte_valid & byte_ready_q;
  // Full count as it will be once the high byte currently on byte_in lands.
  assign count_full = {16'd0, byte_in, count_q[7:0]};
  assign last_word  = (32'(idx_q) == (32'(count_q) - 32'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (xfer) state_d = ST_CNT_HI;
      ST_CNT_HI: begin
        if (xfer) begin
          if (count_full > MAX_W)       state_d = ST_ERROR;
          else if (count_full == 32'd0) state_d = ST_CHECK;
          else                          state_d = ST_DATA;
        end
      end
      // Leave DATA on the lane-3 accept of the last word so a checksum byte
      // can transfer in the very next cycle, alongside that word's strobe.
      ST_DATA:   if (xfer && lane_q == 2'd3 && last_word) state_d = ST_CHECK;
      ST_CHECK:  if (xfer) state_d = (byte_in == chk_q) ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR:  if (start) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      lane_q       <= 2'd0;
      word_q       <= 24'd0;
      chk_q        <= 8'd0;
      byte_ready_q <= 1'b0;
      instr_q      <= 32'd0;
      addr_q       <= BASE_ADDR;
      we_q         <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      // Status outputs are registered from the next state so they change on
      // the same edge as the state register.
      byte_ready_q <= (state_d == ST_IDLE) || (state_d == ST_CNT_HI) ||
                      (state_d == ST_DATA) || (state_d == ST_CHECK);
      done_q       <= (state_d == ST_DONE);
      err_q        <= (state_d == ST_ERROR);
      core_rst_n_q <= (state_d == ST_DONE);

      case (state_q)
        ST_IDLE: begin
          if (xfer) count_q[7:0] <= byte_in;
        end
        ST_CNT_HI: begin
          if (xfer) begin
            count_q[15:8] <= byte_in;
            idx_q         <= '0;
            lane_q        <= 2'd0;
            chk_q         <= 8'd0;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            chk_q  <= chk_q ^ byte_in;
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: word_q[7:0]   <= byte_in;
              2'd1: word_q[15:8]  <= byte_in;
              2'd2: word_q[23:16] <= byte_in;
              default: begin
                instr_q <= {byte_in, word_q};
                addr_q  <= word_addr(BASE_ADDR, 30'(idx_q));
                we_q    <= 1'b1;
                idx_q   <= idx_q + IW'(1);
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign byte_ready    = byte_ready_q;
  assign instr_in      = instr_q;
  assign instr_in_addr = addr_q;
  assign instr_we      = we_q;
  assign core_reset_n  = core_rst_n_q;
  assign done          = done_q;
  assign err           = err_q;
  assign dbg_state_o   = state_q;

endmodule
